// File: rtl/uart_frame_loader.sv
// Framed UART byte-stream loader: decodes WRITE/RUN/HALT frames, writes assembled
// words into one of NUM_TARGETS memories, drives the core run line and answers ACK/NAK.
module uart_frame_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_MODE   = 0,
  parameter int RUN_DELAY   = 100,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   tx_ready,
  output logic                   tx_wr,
  output logic [7:0]             tx_din,
  output logic [NUM_TARGETS-1:0] wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   run,
  output logic                   busy
);
  localparam int          BYTES    = DATA_W / 8;
  localparam int          BC_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int          STEP     = (ADDR_MODE == 0) ? BYTES : 1;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  localparam logic [4:0]  NT       = 5'(NUM_TARGETS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;
  localparam logic [31:0] DLY      = 32'(RUN_DELAY);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [31:0]              addr_raw_q, addr_raw_d;
  logic [15:0]              len_q, len_d;
  logic [15:0]              wcnt_q, wcnt_d;
  logic [DATA_W-1:0]        word_q, word_d;
  logic [BC_W-1:0]          bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
  logic [2:0]               tgt_q, tgt_d;
  logic                     is_run_q, is_run_d, is_halt_q, is_halt_d;
  logic [7:0]               sum_q, sum_d;
  logic [31:0]              tmo_q, tmo_d;
  logic [31:0]              dly_q, dly_d;
  logic                     go_q, go_d;
  logic                     run_q, run_d;
  logic                     tx_wr_q, tx_wr_d;
  logic [7:0]               tx_din_q, tx_din_d;
  logic [NUM_TARGETS-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;

  logic [7:0]               sum_n;
  logic [31:0]              addr_n;
  logic [15:0]              len_n;
  logic [DATA_W-1:0]        word_n;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_raw_d = addr_raw_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    cur_addr_d = cur_addr_q;
    tgt_d      = tgt_q;
    is_run_d   = is_run_q;
    is_halt_d  = is_halt_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    dly_d      = dly_q;
    go_d       = go_q;
    run_d      = run_q;
    tx_wr_d    = 1'b0;
    tx_din_d   = tx_din_q;
    wr_en_d    = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    sum_n      = sum_q + rx_data;
    addr_n     = {rx_data, addr_raw_q[31:8]};
    len_n      = {rx_data, len_q[15:8]};
    word_n     = (word_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));

    if (dly_q != 32'd0) begin
      dly_d = dly_q - 32'd1;
      if (dly_q == 32'd1) run_d = 1'b1;
    end

    // Inter-byte watchdog: any partially assembled word is simply abandoned.
    if (state_q inside {S_ADDR, S_LEN, S_DATA, S_CSUM}) begin
      if (rx_valid) begin
        tmo_d = 32'd0;
      end else if (TIMEOUT != 0) begin
        if (tmo_q == TMO_LAST) begin
          state_d  = S_RESP;
          tx_din_d = NAK;
          tmo_d    = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
    end

    case (state_q)
      S_IDLE: if (rx_valid) begin
        sum_d     = rx_data;
        cnt_d     = 2'd0;
        bcnt_d    = '0;
        wcnt_d    = 16'd0;
        tmo_d     = 32'd0;
        go_d      = 1'b0;
        is_run_d  = 1'b0;
        is_halt_d = 1'b0;
        if (rx_data[7:4] == 4'h1 && {1'b0, rx_data[3:0]} < NT) begin
          tgt_d   = rx_data[2:0];
          state_d = S_ADDR;
          run_d   = 1'b0;
          dly_d   = 32'd0;
        end else if (rx_data == 8'h20) begin
          is_run_d = 1'b1;
          state_d  = S_CSUM;
        end else if (rx_data == 8'h21) begin
          is_halt_d = 1'b1;
          state_d   = S_CSUM;
        end else begin
          tx_din_d = NAK;
          state_d  = S_RESP;
        end
      end
      S_ADDR: if (rx_valid) begin
        sum_d      = sum_n;
        addr_raw_d = addr_n;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d      = 2'd0;
          cur_addr_d = ADDR_W'(addr_n);
          state_d    = S_LEN;
        end
      end
      S_LEN: if (rx_valid) begin
        sum_d = sum_n;
        len_d = len_n;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) state_d = (len_n == 16'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (rx_valid) begin
        sum_d  = sum_n;
        word_d = word_n;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BC_W'(BYTES - 1)) begin
          bcnt_d     = '0;
          wr_en_d    = NUM_TARGETS'(1) << tgt_q;
          wr_data_d  = word_n;
          wr_addr_d  = cur_addr_q;
          cur_addr_d = cur_addr_q + ADDR_W'(STEP);
          wcnt_d     = wcnt_q + 16'd1;
          if (wcnt_q + 16'd1 == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: if (rx_valid) begin
        state_d = S_RESP;
        if (sum_n == 8'h00) begin
          tx_din_d = ACK;
          go_d     = is_run_q;
          if (is_halt_q) begin
            run_d = 1'b0;
            dly_d = 32'd0;
          end
        end else begin
          tx_din_d = NAK;
        end
      end
      S_RESP: if (tx_ready) begin
        tx_wr_d = 1'b1;
        state_d = S_IDLE;
        // A RUN ack (re)starts the delay, anchored to the tx_wr cycle.
        if (go_q) begin
          go_d = 1'b0;
          if (RUN_DELAY == 0) run_d = 1'b1;
          else                dly_d = DLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      addr_raw_q <= 32'd0;
      len_q      <= 16'd0;
      wcnt_q     <= 16'd0;
      word_q     <= '0;
      bcnt_q     <= '0;
      cur_addr_q <= '0;
      tgt_q      <= 3'd0;
      is_run_q   <= 1'b0;
      is_halt_q  <= 1'b0;
      sum_q      <= 8'd0;
      tmo_q      <= 32'd0;
      dly_q      <= 32'd0;
      go_q       <= 1'b0;
      run_q      <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_din_q   <= 8'd0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_raw_q <= addr_raw_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      word_q     <= word_d;
      bcnt_q     <= bcnt_d;
      cur_addr_q <= cur_addr_d;
      tgt_q      <= tgt_d;
      is_run_q   <= is_run_d;
      is_halt_q  <= is_halt_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      dly_q      <= dly_d;
      go_q       <= go_d;
      run_q      <= run_d;
      tx_wr_q    <= tx_wr_d;
      tx_din_q   <= tx_din_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign tx_wr   = tx_wr_q;
  assign tx_din  = tx_din_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign run     = run_q;
  assign busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized frame traffic.
module tb_uart_frame_loader;
  localparam int DW = 32, AW = 32, NT = 2, AM = 0, RD = 100, TMO = 50;
  localparam int BYTES = DW / 8;
  localparam int STEP = (AM == 0) ? BYTES : 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          tx_wr;
  logic [7:0]    tx_din;
  logic [NT-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          run;
  logic          busy;

  uart_frame_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_TARGETS(NT), .ADDR_MODE(AM),
                      .RUN_DELAY(RD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_wr(tx_wr), .tx_din(tx_din), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .run(run), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
  endtask

  // Reference model state: bytes of the frame in progress plus response/run bookkeeping.
  logic [7:0]    fb[$];
  bit            m_resp;
  logic [7:0]    m_resp_b;
  int            m_idle;
  bit            m_run;
  int            m_dly;
  bit            m_go;
  logic [NT-1:0] e_wr_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            e_tx_wr, e_rst;
  logic [7:0]    e_tx_din;
  logic          s_rst, s_rxv, s_rdy;
  logic [7:0]    s_rxd;
  int            cyc = 0;

  function automatic void eval_frame();
    int n = fb.size();
    logic [7:0] cmd = fb[0];
    bit is_wr;
    int total, len, k;
    logic [7:0] s;
    logic [31:0] base;
    is_wr = (cmd[7:4] == 4'h1) && (int'(cmd[3:0]) < NT);
    if (!is_wr && cmd != 8'h20 && cmd != 8'h21) begin
      fb.delete(); m_resp = 1; m_resp_b = 8'h15; return;
    end
    total = 2;
    if (is_wr) begin
      if (n == 1) begin m_run = 0; m_dly = 0; end
      total = 0;
      if (n >= 7) begin
        len = int'(fb[5]) + 256 * int'(fb[6]);
        total = 8 + len * BYTES;
        if (n > 7 && n < total && (n - 7) % BYTES == 0) begin
          k = (n - 7) / BYTES - 1;
          base = {fb[4], fb[3], fb[2], fb[1]};
          e_addr = AW'(base + 32'(k * STEP));
          e_data = '0;
          for (int b = 0; b < BYTES; b++) e_data |= DW'(fb[n - BYTES + b]) << (8 * b);
          e_wr_en = '0;
          e_wr_en[int'(cmd[3:0])] = 1'b1;
        end
      end
    end
    if (n == total) begin
      s = 8'h00;
      foreach (fb[i]) s = s + fb[i];
      if (s == 8'h00) begin
        m_resp_b = 8'h06;
        if (cmd == 8'h20) m_go = 1;
        if (cmd == 8'h21) begin m_run = 0; m_dly = 0; end
      end else m_resp_b = 8'h15;
      fb.delete(); m_resp = 1;
    end
  endfunction

  function automatic void model_step();
    e_wr_en = '0; e_tx_wr = 0; e_rst = 0;
    if (s_rst) begin
      fb.delete(); m_resp = 0; m_idle = 0; m_run = 0; m_dly = 0; m_go = 0; e_rst = 1;
    end else begin
      if (m_dly > 0) begin m_dly--; if (m_dly == 0) m_run = 1; end
      if (m_resp) begin
        if (s_rdy) begin
          e_tx_wr = 1; e_tx_din = m_resp_b; m_resp = 0;
          if (m_go) begin
            if (RD == 0) m_run = 1; else m_dly = RD;
            m_go = 0;
          end
        end
      end else if (s_rxv) begin
        fb.push_back(s_rxd); m_idle = 0; eval_frame();
      end else if (fb.size() > 0) begin
        m_idle++;
        if (TMO != 0 && m_idle == TMO) begin fb.delete(); m_resp = 1; m_resp_b = 8'h15; end
      end
    end
  endfunction

  // DUT event log for literal checks.
  logic [7:0]    last_tx = 8'h00;
  int            last_tx_cyc = 0, n_tx = 0, rise_cyc = 0, n_rise = 0;
  logic          prev_run = 1'b0;
  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];
  logic [NT-1:0] we_log[$];

  always begin
    @(posedge clk);
    s_rst = reset; s_rxv = rx_valid; s_rxd = rx_data; s_rdy = tx_ready;
    cyc++;
    model_step();
    #1;
    chk("wr_en", 64'(wr_en), 64'(e_wr_en));
    chk("tx_wr", 64'(tx_wr), 64'(e_tx_wr));
    chk("run", 64'(run), 64'(m_run));
    chk("busy", 64'(busy), 64'(fb.size() > 0 || m_resp));
    if (e_wr_en != '0) begin
      chk("wr_addr", 64'(wr_addr), 64'(e_addr));
      chk("wr_data", 64'(wr_data), 64'(e_data));
    end
    if (e_tx_wr) chk("tx_din", 64'(tx_din), 64'(e_tx_din));
    if (e_rst) begin
      chk("rst_tx_din", 64'(tx_din), 64'h0);
      chk("rst_wr_addr", 64'(wr_addr), 64'h0);
      chk("rst_wr_data", 64'(wr_data), 64'h0);
    end
    if (tx_wr) begin last_tx = tx_din; last_tx_cyc = cyc; n_tx++; end
    if (wr_en != '0) begin wa_log.push_back(wr_addr); wd_log.push_back(wr_data); we_log.push_back(wr_en); end
    if (run && !prev_run) begin rise_cyc = cyc; n_rise++; end
    prev_run = run;
  end

  bit rnd_rdy = 0;
  initial forever begin
    @(negedge clk);
    if (rnd_rdy) tx_ready = ($urandom_range(0, 3) != 0);
  end

  logic [7:0] frm[$];

  task automatic send_frame(input int gap);
    foreach (frm[i]) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = frm[i];
      for (int g = 0; g < gap; g++) begin @(negedge clk); rx_valid = 1'b0; end
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((fb.size() > 0 || m_resp) && k < 2000) begin @(negedge clk); k++; end
    chk("idle_wait", 64'(k < 2000), 64'h1);
  endtask

  function automatic logic [7:0] csum_of();
    logic [7:0] s = 8'h00;
    foreach (frm[i]) s = s + frm[i];
    return 8'h00 - s;
  endfunction

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); we_log.delete();
  endtask

  initial begin
    int n0, t0, rel, r, len, t;
    logic [31:0] a, w;
    rx_valid = 1'b1; rx_data = 8'h20;
    repeat (3) @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'h0);

    clear_logs();
    frm = '{8'h11, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hD9};
    send_frame(0); wait_idle();
    chk("sw_n", 64'(wd_log.size()), 64'd1);
    chk("sw_en", 64'(we_log[0]), 64'h2);
    chk("sw_addr", 64'(wa_log[0]), 64'h100);
    chk("sw_data", 64'(wd_log[0]), 64'h12345678);
    chk("sw_ack", 64'(last_tx), 64'h06);

    clear_logs();
    frm = '{8'h10, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
            8'h55, 8'h55, 8'hAA, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
    frm.push_back(csum_of());
    send_frame(1); wait_idle();
    chk("wrap_n", 64'(wa_log.size()), 64'd2);
    chk("wrap_a0", 64'(wa_log[0]), 64'hFFFFFFFC);
    chk("wrap_a1", 64'(wa_log[1]), 64'h0);
    chk("wrap_d1", 64'(wd_log[1]), 64'h01020304);
    chk("wrap_ack", 64'(last_tx), 64'h06);

    clear_logs();
    frm = '{8'h11, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hD8};
    send_frame(0); wait_idle();
    chk("bc_written", 64'(wd_log.size()), 64'd1);
    chk("bc_nak", 64'(last_tx), 64'h15);
    chk("bc_run", 64'(run), 64'h0);

    n0 = n_rise;
    frm = '{8'h20, 8'hE0};
    send_frame(0); wait_idle();
    t0 = 0;
    while (n_rise == n0 && t0 < 300) begin @(negedge clk); t0++; end
    chk("run_ack", 64'(last_tx), 64'h06);
    chk("run_delay", 64'(rise_cyc - last_tx_cyc), 64'd100);

    frm = '{8'h11, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hD9};
    send_frame(0); wait_idle();
    chk("wr_clears_run", 64'(run), 64'h0);

    n0 = n_rise;
    frm = '{8'h20, 8'hE0}; send_frame(0); wait_idle();
    repeat (30) @(negedge clk);
    frm = '{8'h21, 8'hDF}; send_frame(0); wait_idle();
    chk("halt_ack", 64'(last_tx), 64'h06);
    repeat (150) @(negedge clk);
    chk("halt_norise", 64'(n_rise - n0), 64'd0);

    clear_logs(); n0 = n_tx;
    frm = '{8'h10, 8'h00, 8'h00}; send_frame(0);
    repeat (60) @(negedge clk);
    chk("tmo_ntx", 64'(n_tx - n0), 64'd1);
    chk("tmo_nak", 64'(last_tx), 64'h15);
    chk("tmo_nowr", 64'(wd_log.size()), 64'd0);
    chk("tmo_busy", 64'(busy), 64'h0);

    tx_ready = 1'b0; n0 = n_tx;
    frm = '{8'h21, 8'hDF}; send_frame(0);
    frm = '{8'h20, 8'hE0}; send_frame(1);
    repeat (20) @(negedge clk);
    chk("bp_hold", 64'(n_tx - n0), 64'd0);
    rel = cyc; tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_tx", 64'(n_tx - n0), 64'd1);
    chk("bp_after", 64'(last_tx_cyc > rel), 64'h1);
    repeat (120) @(negedge clk);
    chk("bp_dropped", 64'(run), 64'h0);

    frm = '{8'h55}; send_frame(0); wait_idle();
    chk("unk_nak", 64'(last_tx), 64'h15);

    frm = '{8'h11, 8'h00, 8'h01}; send_frame(0);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h20;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'h0);

    rnd_rdy = 1;
    for (int it = 0; it < 150; it++) begin
      frm.delete();
      r = $urandom_range(0, 9);
      if (r < 6) begin
        t = $urandom_range(0, 2); a = $urandom(); len = $urandom_range(0, 3);
        frm.push_back(8'h10 | 8'(t));
        for (int b = 0; b < 4; b++) frm.push_back(a[8*b +: 8]);
        frm.push_back(8'(len)); frm.push_back(8'h00);
        for (int j = 0; j < len; j++) begin
          w = $urandom();
          for (int b = 0; b < BYTES; b++) frm.push_back(w[8*b +: 8]);
        end
      end else if (r < 8) frm.push_back(8'h20);
      else if (r == 8)    frm.push_back(8'h21);
      else                frm.push_back(8'($urandom_range(0, 255)));
      frm.push_back(csum_of());
      if ($urandom_range(0, 5) == 0) frm[frm.size() - 1] = frm[frm.size() - 1] + 8'h01;
      if ($urandom_range(0, 11) == 0 && frm.size() > 3) frm.pop_back();
      send_frame($urandom_range(0, 2));
      wait_idle();
    end
    rnd_rdy = 0; tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Byte-stream loader and run controller between a uart_rx byte strobe and the core's memory-write and run inputs.
- Replaces switch-driven loading with a framed protocol. Each frame carries a command, a target memory select, an explicit start address, a word count and a checksum.
- Writes assembled DATA_W-bit words to one of NUM_TARGETS memories and controls the core run line with a programmable start delay.
- Answers every frame with a one-byte ACK or NAK on the UART TX byte interface.

Parameters:
- DATA_W, 32, payload word width; a multiple of 8, from 8 to 64; BYTES = DATA_W/8.
- ADDR_W, 32, width of wr_addr.
- NUM_TARGETS, 2, number of write targets, 1..8; target 0 = insn, target 1 = data.
- ADDR_MODE, 0, address step per word: 0 = byte addressing (step BYTES), 1 = word addressing (step 1).
- RUN_DELAY, 100, cycles from RUN ACK to run rising.
- TIMEOUT, 1000000, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  UART TX can accept a byte
- tx_wr  out  1  one-cycle strobe: send tx_din
- tx_din  out  8  response byte
- wr_en  out  NUM_TARGETS  one-hot write strobe, one cycle per word
- wr_addr  out  ADDR_W  word write address
- wr_data  out  DATA_W  word write data
- run  out  1  core run enable
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE; run, tx_wr, wr_en, busy = 0; tx_din, wr_addr, wr_data = 0; all counters and checksum = 0. Reset mid-frame abandons the frame silently and drops run.
- Frame format: CMD, then body, then CSUM. Frame is valid when the 8-bit sum of every byte, including CSUM, is 0x00.
- Commands:
  - 0x10|t = WRITE to target t.
  - 0x20 = RUN.
  - 0x21 = HALT.
  - Any other CMD, or t >= NUM_TARGETS: tx NAK (0x15) at once, return to IDLE.
- WRITE body: ADDR as 4 bytes LE (truncated or zero-extended to ADDR_W), then LEN as 2 bytes LE (word count), then LEN*BYTES payload bytes, LE within each word.
- State machine: IDLE -> CMD decode -> ADDR -> LEN -> DATA -> CSUM -> RESP -> IDLE.
  - LEN = 0 skips DATA.
  - RUN and HALT go straight from CMD to CSUM.
- Accepting a WRITE CMD clears run on the next cycle.
- Word assembly:
  - Bytes shift in LSB-first.
  - On the cycle after the rx_valid carrying the last byte of a word: wr_en[t]=1 for exactly 1 cycle, wr_data = assembled word, wr_addr = ADDR + k*step, where k is the word index from 0.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Words are committed as they arrive; a bad CSUM does not roll back writes, it only yields NAK.
- CSUM handling:
  - Good sum: ACK (0x06).
  - Good sum on RUN: ACK, then run goes high exactly RUN_DELAY cycles after the ACK tx_wr cycle. RUN_DELAY = 0 means the same cycle as tx_wr.
  - Good sum on HALT: ACK; run goes low and any pending delay count is cancelled on the cycle after CSUM.
  - Bad sum: NAK; run and delay counter unchanged.
- RESP state:
  - Holds tx_din, waits for tx_ready = 1, then pulses tx_wr for 1 cycle and returns to IDLE.
  - rx_valid during RESP is dropped.
- Timeout:
  - In any state other than IDLE and RESP, a counter reloads on each rx_valid.
  - When TIMEOUT cycles pass with no byte: NAK, go to RESP.
  - A partially assembled word is discarded and never written.
- A RUN frame received while the delay count is already pending restarts the count.
- rx_valid in the same cycle as reset is ignored.

Test Plan:
- Single write: 0x11, 00 01 00 00, 01 00, 78 56 34 12, D9 (NUM_TARGETS=2) -> one wr_en=2'b10 pulse, wr_addr=0x100, wr_data=0x12345678; then tx_din=0x06 with tx_wr once.
- Multi-word wrap: WRITE t0, ADDR=0xFFFFFFFC, LEN=2, ADDR_MODE=0 -> writes at 0xFFFFFFFC then 0x00000000; ACK.
- Bad checksum: the single-write frame with CSUM 0xD8 -> word still written, response 0x15, run unchanged.
- Run/halt:
  - 0x20, E0 -> ACK; run rises exactly RUN_DELAY=100 cycles after tx_wr.
  - 0x21, DF sent during the delay -> ACK; run never rises.
  - A WRITE CMD while run=1 -> run low the next cycle.
- Timeout: TIMEOUT=50; send 0x10, 00, 00, then stop -> after 50 idle cycles, NAK, no wr_en, busy returns to 0.
- Back-pressure and error cases:
  - Hold tx_ready=0 for 20 cycles during RESP -> tx_wr only after tx_ready rises; bytes arriving meanwhile are dropped.
  - Unknown CMD 0x55 -> immediate NAK.
